// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART serial transmitter.
// Frames are start bit, DATA_W data bits sent LSB first, an optional parity bit
// and STOP_BITS stop bits, each bit held for CLKS_PER_BIT clocks. The parity
// mode is chosen per word. Words are taken from the host with a valid/ready handshake.
module uart_tx_param #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [1:0]        parity_mode,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned CNT_W  = $clog2(DATA_W + 1);

    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  LAST_DATA = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  LAST_STOP = CNT_W'(STOP_BITS - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]        state;
    logic [BAUD_W-1:0] baud;
    logic [CNT_W-1:0]  bitcnt;
    logic [DATA_W-1:0] shreg;
    logic              par_en;
    logic              par_bit;

    assign tx_ready = (state == IDLE);

    // Frame sequencer: tx/busy/done are loaded with the value of the state
    // being entered, so the line changes on the same edge as the state.
    // bitcnt counts data bits in DATA and is reused to count stop bits in STOP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            baud    <= '0;
            bitcnt  <= '0;
            shreg   <= '0;
            par_en  <= 1'b0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        state   <= START;
                        baud    <= BAUD_LOAD;
                        shreg   <= tx_data;
                        par_en  <= parity_mode[0] ^ parity_mode[1];
                        par_bit <= (^tx_data) ^ parity_mode[1];
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (baud == '0) begin
                        state  <= DATA;
                        baud   <= BAUD_LOAD;
                        bitcnt <= '0;
                        tx     <= shreg[0];
                        shreg  <= shreg >> 1;
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                DATA: begin
                    if (baud == '0) begin
                        baud <= BAUD_LOAD;
                        if (bitcnt == LAST_DATA) begin
                            bitcnt <= '0;
                            if (par_en) begin
                                state <= PARITY;
                                tx    <= par_bit;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                            tx     <= shreg[0];
                            shreg  <= shreg >> 1;
                        end
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                PARITY: begin
                    if (baud == '0) begin
                        state  <= STOP;
                        baud   <= BAUD_LOAD;
                        bitcnt <= '0;
                        tx     <= 1'b1;
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                STOP: begin
                    if (baud == '0) begin
                        if (bitcnt == LAST_STOP) begin
                            state  <= IDLE;
                            bitcnt <= '0;
                            tx     <= 1'b1;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                            baud   <= BAUD_LOAD;
                        end
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: drives two transmitter configurations and compares every
// cycle of tx/busy/done/tx_ready against a frame-sample queue model.
module tb_uart_tx_param;

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic       valid  = 1'b0;
    logic       sel    = 1'b0;
    logic       chk_en = 1'b0;
    logic [8:0] din    = '0;
    logic [1:0] mode   = '0;

    logic valid_a, valid_b;
    logic tx_a, busy_a, done_a, ready_a;
    logic tx_b, busy_b, done_b, ready_b;
    logic obs_tx, obs_busy, obs_done, obs_ready;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    assign valid_a   = valid & ~sel;
    assign valid_b   = valid & sel;
    assign obs_tx    = sel ? tx_b    : tx_a;
    assign obs_busy  = sel ? busy_b  : busy_a;
    assign obs_done  = sel ? done_b  : done_a;
    assign obs_ready = sel ? ready_b : ready_a;

    uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (din[7:0]),
        .tx_valid    (valid_a),
        .tx_ready    (ready_a),
        .parity_mode (mode),
        .tx          (tx_a),
        .busy        (busy_a),
        .done        (done_a)
    );

    uart_tx_param #(.DATA_W(7), .CLKS_PER_BIT(3), .STOP_BITS(2)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (din[6:0]),
        .tx_valid    (valid_b),
        .tx_ready    (ready_b),
        .parity_mode (mode),
        .tx          (tx_b),
        .busy        (busy_b),
        .done        (done_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a frame is a list of line levels, one per clock.
    logic q[$];
    logic m_tx   = 1'b1;
    logic m_busy = 1'b0;
    logic m_done = 1'b0;

    task automatic push_frame(input logic [8:0] d, input logic [1:0] md);
        int unsigned dw    = sel ? 7 : 8;
        int unsigned cpb   = sel ? 3 : 4;
        int unsigned nstop = sel ? 2 : 1;
        logic        par   = 1'b0;
        logic        bits[$];
        bits.push_back(1'b0);
        for (int unsigned i = 0; i < dw; i++) begin
            bits.push_back(d[i]);
            par = par ^ d[i];
        end
        if (md == 2'd1) bits.push_back(par);
        if (md == 2'd2) bits.push_back(~par);
        for (int unsigned i = 0; i < nstop; i++) bits.push_back(1'b1);
        foreach (bits[k])
            for (int unsigned c = 0; c < cpb; c++) q.push_back(bits[k]);
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_tx   <= 1'b1;
            m_busy <= 1'b0;
            m_done <= 1'b0;
        end else begin
            if (valid && !m_busy) push_frame(din, mode);
            if (q.size() > 0) begin
                m_tx   <= q.pop_front();
                m_busy <= 1'b1;
                m_done <= 1'b0;
            end else begin
                m_tx   <= 1'b1;
                m_busy <= 1'b0;
                m_done <= m_busy;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("tx", obs_tx, m_tx);
            check("busy", obs_busy, m_busy);
            check("done", obs_done, m_done);
            check("tx_ready", obs_ready, !m_busy);
        end
    end

    // Called on a falling edge; returns on the falling edge of the first frame cycle.
    task automatic send(input logic [8:0] d, input logic [1:0] md, input bit hold);
        int unsigned w = 0;
        while (!obs_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (w >= 300) check("ready_timeout", 0, 1);
        din   = d;
        mode  = md;
        valid = 1'b1;
        @(negedge clk);
        if (!hold) valid = 1'b0;
    endtask

    task automatic wait_done(output int unsigned n);
        n = 0;
        while (!obs_done && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check("done_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        logic [8:0]  pd [4];
        logic [1:0]  pm [4];
        int unsigned pl [4];
        pd = '{9'h0A5, 9'h0A5, 9'h0A5, 9'h0A5};
        pm = '{2'd1, 2'd2, 2'd0, 2'd3};
        pl = '{44, 44, 40, 40};

        // Reset held with a word offered: nothing may be accepted.
        din   = 9'h0C3;
        mode  = 2'd1;
        valid = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("rst_tx", obs_tx, 1);
            check("rst_ready", obs_ready, 1);
            check("rst_busy", obs_busy, 0);
            check("rst_done", obs_done, 0);
        end
        rst = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        check("rel_start", obs_tx, 0);
        wait_done(n);
        check("rel_len", n, 44);

        // Parity modes on the 8-bit configuration.
        for (int i = 0; i < 4; i++) begin
            send(pd[i], pm[i], 1'b0);
            wait_done(n);
            check("frame_len", n, pl[i]);
            @(negedge clk);
            check("done_pulse", obs_done, 0);
        end

        // Back-to-back with valid held high.
        send(9'h000, 2'd0, 1'b1);
        din = 9'h0FF;
        wait_done(n);
        check("b2b_len1", n, 40);
        check("b2b_ready", obs_ready, 1);
        check("b2b_busy", obs_busy, 0);
        @(negedge clk);
        valid = 1'b0;
        check("b2b_start", obs_tx, 0);
        wait_done(n);
        check("b2b_len2", n, 40);
        @(negedge clk);

        // 7-bit, 2 stop bits, 3 clocks per bit.
        sel = 1'b1;
        @(negedge clk);
        send(9'h07F, 2'd2, 1'b0);
        wait_done(n);
        check("b_len", n, 33);
        @(negedge clk);
        sel = 1'b0;
        @(negedge clk);

        // Mid-frame disturbance, then reset during data bit 3.
        send(9'h03C, 2'd1, 1'b0);
        repeat (5) @(negedge clk);
        din   = 9'h1FF;
        mode  = 2'd2;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (11) @(negedge clk);
        check("pre_rst_busy", obs_busy, 1);
        #1 rst = 1'b0;
        #1;
        check("abort_tx", obs_tx, 1);
        check("abort_busy", obs_busy, 0);
        check("abort_ready", obs_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        send(9'h096, 2'd2, 1'b0);
        wait_done(n);
        check("post_rst_len", n, 44);

        // Randomised frames on both configurations.
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            @(negedge clk);
            sel = (s == 1);
            @(negedge clk);
            for (int f = 0; f < 25; f++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send(9'($urandom), 2'($urandom_range(0, 3)), 1'b0);
                din  = 9'($urandom);
                mode = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 1) wait_done(n);
            end
            wait_done(n);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
